sync_fifo_16x8: RTL and testbench
=================================

// Module: sync_fifo_16x8
// PURPOSE
//  Single-clock, 16-entry x 8-bit synchronous FIFO with registered read data.
//  Provides empty, partially-empty, full and partially-full status flags.
//  Sits between a byte producer (e.g. the LFSR data source) and a byte consumer.
//  The RTL implementation must match the behavioural model cycle-for-cycle on every output.
// PARAMETERS
//  WIDTH      8   data width in bits
//  DEPTH      16  number of entries (power of two)
//  AW         4   address width, log2(DEPTH)
//  PE_THRESH  4   PEF asserted when 0 < count <= PE_THRESH
//  PF_THRESH  12  PFF asserted when PF_THRESH <= count < DEPTH
// PORTS
//  clk      in   1      clock; all state changes on rising edge
//  RESET    in   1      reset, asynchronous, active-low (0 = in reset)
//  DATA_IN  in   WIDTH  write data
//  WE       in   1      write enable, active high
//  RE       in   1      read enable, active high
//  DOUT     out  WIDTH  read data, registered
//  EF       out  1      empty flag (count == 0)
//  PEF      out  1      partially-empty flag
//  FF       out  1      full flag (count == DEPTH)
//  PFF      out  1      partially-full flag
// BEHAVIOUR
//  - Reset (RESET=0, async, overrides everything): write ptr=0, read ptr=0,
//    count=0, DOUT=0, EF=1, PEF=0, FF=0, PFF=0. Memory contents are not cleared.
//  - Write accepted at posedge when WE=1 and (FF=0 or a read is accepted in the same cycle).
//    Effect: mem[wptr]<=DATA_IN; wptr<=wptr+1.
//  - Read accepted at posedge when RE=1 and EF=0.
//    Effect: DOUT<=mem[rptr]; rptr<=rptr+1. Latency is 1 clock; DOUT is valid after that edge.
//  - Read when empty: ignored; DOUT holds. No write-through bypass, even when WE=1.
//  - Write when full with no read: ignored; pointers, count and memory unchanged.
//  - Simultaneous accepted read and write: both execute; count is unchanged.
//    When full, the read frees the slot the write uses.
//  - Pointers are AW bits and wrap modulo DEPTH (15 -> 0).
//    count is AW+1 bits, range 0..DEPTH.
//  - Flags are registered and computed from the next count, so they reflect post-edge occupancy.
//    EF: count==0.  PEF: 1..4.  PFF: 12..15.  FF: count==16.
//    PEF and PFF are never set together with EF or FF.
//  - Reset mid-operation: reset values take effect immediately.
//    The first accepted write after release lands in entry 0.
//  - With RESET=1, no X on any output.
// STRUCTURE
//  - Shared package fifo_pkg holds WIDTH, DEPTH, AW, PE_THRESH and PF_THRESH.
//  - One sub-module, fifo_regfile: a DEPTH x WIDTH register array with one sync write port
//    and one async read port.
//  - Top level holds pointers, count, flag registers and the DOUT register.
// TESTING
//  1 Reset: RESET=0 for 2 cycles -> DOUT=0, EF=1, PEF=0, FF=0, PFF=0.
//  2 Fill: after reset, WE=1/RE=0 for 16 cycles with data 1..16.
//    -> EF drops after the 1st edge; PEF=1 for counts 1..4; PFF=1 for counts 12..15;
//    FF=1 after the 16th edge; a 17th write (0xAA) is ignored.
//  3 Drain: RE=1/WE=0 for 17 cycles -> DOUT=1,2,..,16 in order; flags retrace in reverse.
//    EF=1 after the 16th read; on the 17th read DOUT holds 16.
//  4 Simultaneous: at count=5, WE=RE=1 for 8 cycles -> count stays 5 and DOUT streams in FIFO order.
//    When full, WE=RE=1 -> FF stays 1 and the oldest word is output.
//  5 Wrap: write/read 40 words with occupancy between 0 and 16 -> output sequence equals input
//    sequence, with no loss or duplication across the 15->0 pointer wrap.
//  6 Mid-op reset: pulse RESET=0 asynchronously (not clock-aligned) at count=9.
//    -> outputs take reset values before the next edge; the next write-then-read returns
//    the newly written word.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared sizing and flag thresholds for the 16x8 synchronous FIFO.
package fifo_pkg;

    localparam int WIDTH = 8;
    localparam int DEPTH = 16;
    localparam int AW    = 4;

    typedef logic [AW:0] cnt_t;

    localparam cnt_t PE_THRESH = cnt_t'(4);
    localparam cnt_t PF_THRESH = cnt_t'(12);
    localparam cnt_t CNT_FULL  = cnt_t'(DEPTH);

endpackage

// File: rtl/fifo_regfile.sv
// DEPTH x WIDTH register array: one synchronous write port, one async read port.
module fifo_regfile
    import fifo_pkg::*;
(
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Storage is deliberately left unreset; only written entries are ever read.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo_16x8.sv
// Single-clock 16x8 FIFO with registered read data and registered status flags.
module sync_fifo_16x8
    import fifo_pkg::*;
(
    input  logic             clk,
    input  logic             RESET,
    input  logic [WIDTH-1:0] DATA_IN,
    input  logic             WE,
    input  logic             RE,
    output logic [WIDTH-1:0] DOUT,
    output logic             EF,
    output logic             PEF,
    output logic             FF,
    output logic             PFF
);

    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    cnt_t             count;
    cnt_t             count_nxt;
    logic             rd_ok;
    logic             wr_ok;
    logic [WIDTH-1:0] rdata;

    // A read in the same cycle frees the slot a write into a full FIFO needs.
    assign rd_ok = RE && !EF;
    assign wr_ok = WE && (!FF || rd_ok);

    always_comb begin
        count_nxt = count;
        unique case ({wr_ok, rd_ok})
            2'b10:   count_nxt = count + cnt_t'(1);
            2'b01:   count_nxt = count - cnt_t'(1);
            default: count_nxt = count;
        endcase
    end

    fifo_regfile u_regfile (
        .clk   (clk),
        .we    (wr_ok),
        .waddr (wptr),
        .wdata (DATA_IN),
        .raddr (rptr),
        .rdata (rdata)
    );

    always_ff @(posedge clk or negedge RESET) begin
        if (!RESET) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
            DOUT  <= '0;
            EF    <= 1'b1;
            PEF   <= 1'b0;
            FF    <= 1'b0;
            PFF   <= 1'b0;
        end else begin
            if (wr_ok) begin
                wptr <= wptr + AW'(1);
            end
            if (rd_ok) begin
                rptr <= rptr + AW'(1);
                DOUT <= rdata;
            end
            count <= count_nxt;
            EF    <= (count_nxt == '0);
            PEF   <= (count_nxt != '0) && (count_nxt <= PE_THRESH);
            FF    <= (count_nxt == CNT_FULL);
            PFF   <= (count_nxt >= PF_THRESH) && (count_nxt < CNT_FULL);
        end
    end

endmodule

// File: tb/tb_sync_fifo_16x8.sv
// Scoreboard bench for sync_fifo_16x8 against a queue-based reference model.
module tb_sync_fifo_16x8;

    typedef struct packed {
        logic [7:0] dout;
        logic       ef;
        logic       pef;
        logic       ff;
        logic       pff;
    } exp_t;

    logic       clk;
    logic       RESET;
    logic [7:0] DATA_IN;
    logic       WE;
    logic       RE;
    logic [7:0] DOUT;
    logic       EF;
    logic       PEF;
    logic       FF;
    logic       PFF;

    int n_checks;
    int n_fail;

    logic [7:0] model_q[$];
    logic [7:0] model_dout;
    exp_t       exp_q[$];
    logic       last_wr;
    logic       last_rd;

    sync_fifo_16x8 dut (
        .clk     (clk),
        .RESET   (RESET),
        .DATA_IN (DATA_IN),
        .WE      (WE),
        .RE      (RE),
        .DOUT    (DOUT),
        .EF      (EF),
        .PEF     (PEF),
        .FF      (FF),
        .PFF     (PFF)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic exp_t model_flags();
        exp_t e;
        int n;
        n = model_q.size();
        e.dout = model_dout;
        e.ef   = (n == 0);
        e.pef  = (n >= 1) && (n <= 4);
        e.ff   = (n == 16);
        e.pff  = (n >= 12) && (n <= 15);
        return e;
    endfunction

    // One clock of stimulus: drive inputs, advance the model, queue the expectation.
    task automatic cyc(input logic we, input logic re, input logic [7:0] d);
        @(negedge clk);
        WE      = we;
        RE      = re;
        DATA_IN = d;
        last_rd = re && (model_q.size() > 0);
        last_wr = we && ((model_q.size() < 16) || last_rd);
        if (last_rd) model_dout = model_q.pop_front();
        if (last_wr) model_q.push_back(d);
        exp_q.push_back(model_flags());
    endtask

    // Monitor: every expectation queued before an edge is compared just after it.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("dout", DOUT, e.dout);
                check("ef", {7'd0, EF}, {7'd0, e.ef});
                check("pef", {7'd0, PEF}, {7'd0, e.pef});
                check("ff", {7'd0, FF}, {7'd0, e.ff});
                check("pff", {7'd0, PFF}, {7'd0, e.pff});
            end
        end
    end

    task automatic check_reset_vals(input string name);
        check({name, "_dout"}, DOUT, 8'h00);
        check({name, "_flags"}, {4'd0, EF, PEF, FF, PFF}, 8'b0000_1000);
    endtask

    initial begin
        int written;
        int guard;
        n_checks   = 0;
        n_fail     = 0;
        model_dout = 8'h00;
        last_wr    = 1'b0;
        last_rd    = 1'b0;
        RESET      = 1'b0;
        WE         = 1'b0;
        RE         = 1'b0;
        DATA_IN    = 8'h00;

        repeat (2) @(negedge clk);
        check_reset_vals("reset");
        RESET = 1'b1;

        for (int i = 1; i <= 16; i++) cyc(1'b1, 1'b0, 8'(i));
        cyc(1'b1, 1'b0, 8'hAA);
        check("fill_ignored", {7'd0, last_wr}, 8'd0);

        for (int i = 0; i < 17; i++) cyc(1'b0, 1'b1, 8'h00);

        for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, 8'($urandom));
        for (int i = 0; i < 8; i++) cyc(1'b1, 1'b1, 8'($urandom));
        while (model_q.size() < 16) cyc(1'b1, 1'b0, 8'($urandom));
        for (int i = 0; i < 4; i++) cyc(1'b1, 1'b1, 8'($urandom));
        while (model_q.size() > 0) cyc(1'b0, 1'b1, 8'h00);

        written = 0;
        guard   = 0;
        while ((written < 40 || model_q.size() > 0) && guard < 600) begin
            cyc((written < 40) && ($urandom_range(0, 2) != 0),
                $urandom_range(0, 1) == 1, 8'($urandom));
            if (last_wr) written++;
            guard++;
        end
        check("wrap_bound", {7'd0, guard >= 600}, 8'd0);

        for (int i = 0; i < 9; i++) cyc(1'b1, 1'b0, 8'($urandom));
        @(negedge clk);
        WE = 1'b0;
        RE = 1'b0;
        #3 RESET = 1'b0;
        #1 check_reset_vals("midop");
        #1 RESET = 1'b1;
        model_q.delete();
        model_dout = 8'h00;
        exp_q.push_back(model_flags());

        cyc(1'b1, 1'b0, 8'h5C);
        cyc(1'b0, 1'b1, 8'h00);
        check("midop_model", model_dout, 8'h5C);
        cyc(1'b0, 1'b0, 8'h00);
        cyc(1'b0, 1'b0, 8'h00);

        repeat (2) @(posedge clk);
        #2;
        check("scoreboard_drained", 8'(exp_q.size()), 8'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
